// File: rtl/shift_sequencer.sv
// Purpose: multi-cycle sequencer applying one 1-bit left/right shift (logical or rotate) per clock.
// Latency: busy for k = min(amount,N) cycles after the start edge, then a one-cycle done pulse.
// Backpressure: none; start is ignored while busy and accepted only in IDLE or DONE.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start              request a new operation (captures data_in/amount/direction/rotate)
//   data_in [N]        operand
//   amount  [AMT_W]    number of 1-bit shifts, clamped to N
//   direction          1 = left (towards MSB), 0 = right
//   rotate             1 = rotate, 0 = logical (zero fill)
//   busy               high while shift steps are in progress
//   done               single-cycle pulse, result valid
//   result  [N]        working/final operand, held until the next accepted start
//   shift_out          last bit shifted out (0 if no shift performed)
module shift_sequencer #(
  parameter int N     = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             direction,
  input  logic             rotate,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     result,
  output logic             shift_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] N_AMT = AMT_W'(N);

  state_t           state_q, state_d;
  logic [N-1:0]     result_q, result_d;
  logic             shift_out_q, shift_out_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;

  logic [AMT_W-1:0] amt_clamped;
  logic             out_bit;

  // Anything beyond N steps would be redundant: N logical steps clear the
  // operand and N rotate steps restore it.
  assign amt_clamped = (amount > N_AMT) ? N_AMT : amount;

  // Bit leaving the operand on this step; also the fill bit when rotating.
  assign out_bit = dir_q ? result_q[N-1] : result_q[0];

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    shift_out_d = shift_out_q;
    dir_d       = dir_q;
    rot_d       = rot_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_SHIFT: begin
        if (dir_q) begin
          result_d = {result_q[N-2:0], rot_q & out_bit};
        end else begin
          result_d = {rot_q & out_bit, result_q[N-1:1]};
        end
        shift_out_d = out_bit;
        cnt_d       = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Start wins over the IDLE/DONE defaults above, giving back-to-back
    // operation straight out of DONE.
    if (start && (state_q != ST_SHIFT)) begin
      result_d    = data_in;
      shift_out_d = 1'b0;
      dir_d       = direction;
      rot_d       = rotate;
      cnt_d       = amt_clamped;
      state_d     = (amt_clamped == '0) ? ST_DONE : ST_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      shift_out_q <= 1'b0;
      dir_q       <= 1'b0;
      rot_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      shift_out_q <= shift_out_d;
      dir_q       <= dir_d;
      rot_q       <= rot_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign shift_out = shift_out_q;

endmodule
